f1_sweep_driver: RTL and testbench
==================================

// Module: f1_sweep_driver
// PURPOSE
//  Upstream stimulus/capture stage for the 4-input f1 NAND network. On a start pulse it walks
//  {a,b,c,d} through all 16 input combinations, waits a fixed settle time per vector, samples
//  f1 and builds the 16-bit truth table. Used on the lab board to verify f1 hardware exhaustively.
// PARAMETERS
//  SETTLE_CYCLES  2         cycles {a,b,c,d} is held before f1 is sampled; legal range 1..15
//  EXPECTED       16'h8DC5  golden truth table, bit[i] = f1 at {a,b,c,d}=i; used only under TT_CHECK_EN
// PORTS
//  clk          in   1   single clock; all state changes on rising edge
//  rst_n        in   1   asynchronous reset, active-low
//  start        in   1   start sweep; sampled only in IDLE
//  abort        in   1   synchronous abort; wins over all other activity except reset
//  f1           in   1   output of the f1 network under test
//  a,b,c,d      out  1   registered stimulus; a = MSB of vector index, d = LSB
//  vec_idx      out  4   index of the vector currently being driven
//  busy         out  1   high in SETTLE and SAMPLE
//  done         out  1   one-cycle pulse when the table is published
//  table_valid  out  1   truth_table holds a complete sweep
//  truth_table  out  16  bit[i] = sampled f1 for vector i
//  match        out  1   truth_table == EXPECTED (TT_CHECK_EN only)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; a..d=0, vec_idx=0, busy=0, done=0, table_valid=0,
//    truth_table=0, match=0; settle counter and shadow table cleared.
//  - FSM states: IDLE, SETTLE, SAMPLE, DONE.
//    IDLE   : start=1 -> SETTLE; vec_idx=0; {a,b,c,d}=0; settle cnt=0; table_valid cleared.
//    SETTLE : cnt increments every cycle; on the cycle cnt==SETTLE_CYCLES-1 -> SAMPLE.
//    SAMPLE : shadow[vec_idx] <= f1 (one cycle). If vec_idx==15 -> DONE.
//             Otherwise vec_idx++, {a,b,c,d} follows it on the same edge, cnt=0, -> SETTLE.
//    DONE   : truth_table <= shadow; table_valid=1; done=1 for this cycle only; -> IDLE.
//  - Each vector occupies SETTLE_CYCLES+1 cycles. done is high in the cycle that begins
//    16*(SETTLE_CYCLES+1) rising edges after the edge on which start was accepted:
//    48 edges at the default. Equivalently, done is high in the 49th cycle counting the
//    first SETTLE cycle as cycle 1.
//  - {a,b,c,d} changes only on a vector-advance edge, on the start edge (to 0), and on abort or
//    reset (to 0). Stimulus is never glitched mid-vector.
//  - start while busy, or in DONE: ignored. No restart, no queuing.
//  - abort=1 in any state: next edge -> IDLE; a..d=0; vec_idx=0; busy=0; table_valid=0; match=0.
//    truth_table keeps its last published value. No done pulse is produced.
//  - start and abort in the same IDLE cycle: abort wins and the sweep is not started.
//  - table_valid stays 1 after DONE until the next accepted start, an abort, or reset.
//  - vec_idx wraps only via IDLE. It never counts past 15.
// CONFIGURATION
//  - TT_CHECK_EN defined: in DONE, match <= (shadow == EXPECTED), registered in the same cycle
//    as truth_table. match is cleared on an accepted start, abort and reset.
//  - TT_CHECK_EN undefined: match is tied to 0 and EXPECTED is unused. The port is still present.
// TESTING
//  1 Reset: rst_n=0 mid-clock -> all outputs 0 immediately (asynchronous), no clk edge required.
//  2 Golden sweep: f1 driven by a behavioural f1 = ~b&~d | ~a&b&c | a&c&d; pulse start ->
//    a..d step 0..15 with each value held 3 cycles; done=1 in cycle 49; truth_table=16'h8DC5;
//    table_valid=1; match=1 (with macro).
//  3 Stuck-at fault: f1 tied to 1; run sweep -> truth_table=16'hFFFF; match=0 with macro,
//    0 without macro.
//  4 Start while busy: extra start pulses at vec_idx=3 and in DONE -> exactly one done pulse,
//    timing identical to scenario 2.
//  5 Abort mid-sweep: assert abort when vec_idx=7 -> next cycle IDLE, a..d=0, busy=0,
//    table_valid=0; truth_table keeps its previous value; no done pulse.
//  6 Reset mid-sweep, then SETTLE_CYCLES=1 rerun: deassert rst_n at vec_idx=10 -> IDLE;
//    rerun -> done in cycle 33; truth_table=16'h8DC5.

Source files
------------

// File: rtl/f1_sweep_driver_if.sv
// f1 sweep driver bus: control inputs, stimulus outputs and truth-table results.
// Latency: none, signal bundle only.
// Backpressure: none; start/abort are level-sampled by the driver.
// Ports (as seen by the driver, slave modport):
//   start, abort, f1                       -> into the driver
//   a, b, c, d, vec_idx, busy, done,
//   table_valid, truth_table, match        <- out of the driver
interface f1_sweep_driver_if;
  logic        start;
  logic        abort;
  logic        f1;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic [3:0]  vec_idx;
  logic        busy;
  logic        done;
  logic        table_valid;
  logic [15:0] truth_table;
  logic        match;

  // Controller / lab-board side: issues start/abort, returns f1.
  modport master (
    output start, abort, f1,
    input  a, b, c, d, vec_idx, busy, done, table_valid, truth_table, match
  );

  // Sweep driver side.
  modport slave (
    input  start, abort, f1,
    output a, b, c, d, vec_idx, busy, done, table_valid, truth_table, match
  );
endinterface

// File: rtl/f1_sweep_driver.sv
// Exhaustive 16-vector stimulus/capture of the f1 NAND network into a truth table.
// Latency: done pulses 16*(SETTLE_CYCLES+1) edges after the start edge; table visible the cycle after done.
// Backpressure: none; start is ignored unless idle, abort returns to idle on the next edge.
// Ports: clk, rst_n (async active-low); bus (f1_sweep_driver_if.slave) carries
//   start/abort/f1 in and a..d, vec_idx, busy, done, table_valid, truth_table, match out.
// Optional feature: define TT_CHECK_EN to compare each published table against EXPECTED
//   and drive match; without it match is tied low.
module f1_sweep_driver #(
  parameter int          SETTLE_CYCLES = 2,       // 1..15 cycles a vector is held before sampling
  parameter logic [15:0] EXPECTED      = 16'h8DC5 // golden table, bit[i] = f1 at vector i
) (
  input  logic               clk,
  input  logic               rst_n,
  f1_sweep_driver_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] tt_q, tt_d;
  logic        tv_q, tv_d;

`ifdef TT_CHECK_EN
  logic        match_q, match_d;
`else
  // EXPECTED only matters when the check is built in.
  logic        unused_expected;
  assign unused_expected = ^EXPECTED;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      tt_q     <= '0;
      tv_q     <= 1'b0;
`ifdef TT_CHECK_EN
      match_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      tt_q     <= tt_d;
      tv_q     <= tv_d;
`ifdef TT_CHECK_EN
      match_q  <= match_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    tt_d     = tt_q;
    tv_d     = tv_q;
`ifdef TT_CHECK_EN
    match_d  = match_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETTLE;
          idx_d   = '0;
          cnt_d   = '0;
          tv_d    = 1'b0;
`ifdef TT_CHECK_EN
          match_d = 1'b0;
`endif
        end
      end
      SETTLE: begin
        // cnt runs freely here; SAMPLE reloads it, so a wrap at 15 is harmless.
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        shadow_d[idx_q] = bus.f1;
        if (idx_q == 4'd15) begin
          // idx stays at 15: the stimulus is held until the next start/abort.
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      DONE: begin
        tt_d    = shadow_q;
        tv_d    = 1'b1;
`ifdef TT_CHECK_EN
        match_d = (shadow_q == EXPECTED);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a start seen in the same cycle.
    // The last published truth_table is deliberately kept.
    if (bus.abort) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      tt_d    = tt_q;
      tv_d    = 1'b0;
`ifdef TT_CHECK_EN
      match_d = 1'b0;
`endif
    end
  end

  // Stimulus is the index register itself, so it can only move on an index update.
  assign {bus.a, bus.b, bus.c, bus.d} = idx_q;
  assign bus.vec_idx     = idx_q;
  assign bus.busy        = (state_q == SETTLE) || (state_q == SAMPLE);
  assign bus.done        = (state_q == DONE);
  assign bus.table_valid = tv_q;
  assign bus.truth_table = tt_q;
`ifdef TT_CHECK_EN
  assign bus.match       = match_q;
`else
  assign bus.match       = 1'b0;
`endif

endmodule

// File: tb/tb_f1_sweep_driver.sv
// Bench for f1_sweep_driver: two instances (settle 2 and settle 1), f1 modelled per instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_f1_sweep_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  f1_sweep_driver_if sif0 ();
  f1_sweep_driver_if sif1 ();

  f1_sweep_driver #(.SETTLE_CYCLES(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(sif0.slave));
  f1_sweep_driver #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(sif1.slave));

  int errors = 0;
  int checks = 0;

  logic        st [2];
  logic        ab [2];
  int          fmode [2];   // 0 = golden f1, 1 = stuck-at-1, 2 = random table
  logic [15:0] rtt [2];
  logic [15:0] last_tt [2]; // model of the last published table per instance

  logic [3:0]  o_vec [2];
  logic [3:0]  o_abcd [2];
  logic        o_busy [2];
  logic        o_done [2];
  logic        o_tv [2];
  logic        o_match [2];
  logic [15:0] o_tt [2];

  assign sif0.start = st[0];
  assign sif0.abort = ab[0];
  assign sif1.start = st[1];
  assign sif1.abort = ab[1];

  assign o_vec[0]   = sif0.vec_idx;
  assign o_abcd[0]  = {sif0.a, sif0.b, sif0.c, sif0.d};
  assign o_busy[0]  = sif0.busy;
  assign o_done[0]  = sif0.done;
  assign o_tv[0]    = sif0.table_valid;
  assign o_match[0] = sif0.match;
  assign o_tt[0]    = sif0.truth_table;
  assign o_vec[1]   = sif1.vec_idx;
  assign o_abcd[1]  = {sif1.a, sif1.b, sif1.c, sif1.d};
  assign o_busy[1]  = sif1.busy;
  assign o_done[1]  = sif1.done;
  assign o_tv[1]    = sif1.table_valid;
  assign o_match[1] = sif1.match;
  assign o_tt[1]    = sif1.truth_table;

  function automatic logic fval(int mode, logic [3:0] v, logic [15:0] tt);
    logic a, b, c, d;
    {a, b, c, d} = v;
    case (mode)
      0:       return (~b & ~d) | (~a & b & c) | (a & c & d);
      1:       return 1'b1;
      default: return tt[v];
    endcase
  endfunction

  function automatic logic [15:0] model_tt(int mode, logic [15:0] tt);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i] = fval(mode, 4'(i), tt);
    return r;
  endfunction

  function automatic logic exp_match(logic [15:0] tt);
`ifdef TT_CHECK_EN
    return (tt == 16'h8DC5);
`else
    return 1'b0;
`endif
  endfunction

  always_comb sif0.f1 = fval(fmode[0], o_abcd[0], rtt[0]);
  always_comb sif1.f1 = fval(fmode[1], o_abcd[1], rtt[1]);

  // One full sweep on instance s with per = SETTLE_CYCLES+1, checked cycle by cycle.
  // Cycle k = 1 is the first cycle after the start edge; done is due in cycle 16*per+1.
  task automatic run_sweep(int s, int per, logic [15:0] exp_tt, bit extra_start, string name);
    int n;
    logic [3:0] ev;
    n = 16 * per;
    @(negedge clk); st[s] = 1'b1;
    @(negedge clk); st[s] = 1'b0;
    for (int k = 1; k <= n + 1; k++) begin
      if (k > 1) @(negedge clk);
      st[s] = 1'b0;
      ev = (k <= n) ? 4'((k - 1) / per) : 4'd15;
      checks++;
      if (o_vec[s] !== ev || o_abcd[s] !== ev) begin
        errors++;
        $display("FAIL %s vec k=%0d got vec=%0d abcd=%0d exp %0d", name, k, o_vec[s], o_abcd[s], ev);
      end
      checks++;
      if (o_busy[s] !== (k <= n)) begin
        errors++;
        $display("FAIL %s busy k=%0d got %b exp %b", name, k, o_busy[s], (k <= n));
      end
      checks++;
      if (o_done[s] !== (k == n + 1)) begin
        errors++;
        $display("FAIL %s done k=%0d got %b exp %b", name, k, o_done[s], (k == n + 1));
      end
      if (k <= n) begin
        checks++;
        if (o_tv[s] !== 1'b0 || o_tt[s] !== last_tt[s]) begin
          errors++;
          $display("FAIL %s hold k=%0d got tv=%b tt=%h exp tv=0 tt=%h", name, k, o_tv[s], o_tt[s], last_tt[s]);
        end
      end
      if (extra_start && ((k <= n && ev == 4'd3) || k == n + 1)) st[s] = 1'b1;
    end
    @(negedge clk); st[s] = 1'b0;
    last_tt[s] = exp_tt;
    checks++;
    if (o_tv[s] !== 1'b1 || o_tt[s] !== exp_tt) begin
      errors++;
      $display("FAIL %s table got tv=%b tt=%h exp tv=1 tt=%h", name, o_tv[s], o_tt[s], exp_tt);
    end
    checks++;
    if (o_match[s] !== exp_match(exp_tt)) begin
      errors++;
      $display("FAIL %s match got %b exp %b", name, o_match[s], exp_match(exp_tt));
    end
    checks++;
    if (o_busy[s] !== 1'b0 || o_done[s] !== 1'b0 || o_abcd[s] !== 4'd15) begin
      errors++;
      $display("FAIL %s idle got busy=%b done=%b abcd=%0d exp 0 0 15", name, o_busy[s], o_done[s], o_abcd[s]);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (o_done[s] !== 1'b0 || o_busy[s] !== 1'b0 || o_tv[s] !== 1'b1) begin
        errors++;
        $display("FAIL %s post got done=%b busy=%b tv=%b exp 0 0 1", name, o_done[s], o_busy[s], o_tv[s]);
      end
    end
  endtask

  task automatic check_zero(int s, string name);
    checks++;
    if (o_vec[s] !== 4'd0 || o_abcd[s] !== 4'd0 || o_busy[s] !== 1'b0 || o_done[s] !== 1'b0 ||
        o_tv[s] !== 1'b0 || o_tt[s] !== 16'h0 || o_match[s] !== 1'b0) begin
      errors++;
      $display("FAIL %s got vec=%0d abcd=%0d busy=%b done=%b tv=%b tt=%h match=%b exp all 0",
               name, o_vec[s], o_abcd[s], o_busy[s], o_done[s], o_tv[s], o_tt[s], o_match[s]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      st[s] = 1'b0; ab[s] = 1'b0; fmode[s] = 0; rtt[s] = '0; last_tt[s] = '0;
    end
    #1;
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_zero(0, "reset0_idle");
  endtask

  task automatic test_golden();
    fmode[0] = 0;
    run_sweep(0, 3, 16'h8DC5, 1'b0, "golden");
    checks++;
    if (model_tt(0, '0) !== 16'h8DC5) begin
      errors++;
      $display("FAIL golden_model got %h exp 8dc5", model_tt(0, '0));
    end
  endtask

  task automatic test_stuck();
    fmode[0] = 1;
    run_sweep(0, 3, 16'hFFFF, 1'b0, "stuck1");
  endtask

  task automatic test_back_to_back();
    fmode[0] = 0;
    run_sweep(0, 3, 16'h8DC5, 1'b1, "start_busy");
  endtask

  task automatic test_abort();
    int dones;
    fmode[0] = 2;
    rtt[0] = 16'($urandom);
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    repeat (21) @(negedge clk);
    checks++;
    if (o_vec[0] !== 4'd7) begin
      errors++;
      $display("FAIL abort_pre vec got %0d exp 7", o_vec[0]);
    end
    ab[0] = 1'b1;
    @(negedge clk); ab[0] = 1'b0;
    checks++;
    if (o_vec[0] !== 4'd0 || o_abcd[0] !== 4'd0 || o_busy[0] !== 1'b0 || o_tv[0] !== 1'b0 ||
        o_match[0] !== 1'b0 || o_tt[0] !== last_tt[0]) begin
      errors++;
      $display("FAIL abort got vec=%0d abcd=%0d busy=%b tv=%b match=%b tt=%h exp 0 0 0 0 0 %h",
               o_vec[0], o_abcd[0], o_busy[0], o_tv[0], o_match[0], o_tt[0], last_tt[0]);
    end
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (o_done[0] === 1'b1 || o_busy[0] === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles exp 0", dones);
    end
    st[0] = 1'b1; ab[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0; ab[0] = 1'b0;
    dones = 0;
    repeat (4) begin
      if (o_busy[0] !== 1'b0) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_vs_start got %0d busy cycles exp 0", dones);
    end
  endtask

  task automatic test_reset_mid_rerun();
    fmode[0] = 0;
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (o_vec[0] !== 4'd10) begin
      errors++;
      $display("FAIL rst_mid_pre vec got %0d exp 10", o_vec[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    check_zero(0, "rst_mid_async");
    last_tt[0] = '0;
    last_tt[1] = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_zero(0, "rst_mid_idle");
    fmode[1] = 0;
    run_sweep(1, 2, 16'h8DC5, 1'b0, "settle1_golden");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      fmode[1] = 2;
      rtt[1] = 16'($urandom);
      run_sweep(1, 2, model_tt(2, rtt[1]), ($urandom_range(0, 1) == 1), "random1");
    end
    fmode[0] = 2;
    rtt[0] = 16'($urandom);
    run_sweep(0, 3, model_tt(2, rtt[0]), 1'b0, "random0");
  endtask

  initial begin
    test_reset();
    test_golden();
    test_stuck();
    test_back_to_back();
    test_abort();
    test_reset_mid_rerun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
